// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller and its dispense stage.
package vend_pkg;

  localparam int GOODS_W         = 3;
  localparam int CHANGE_W        = 3;
  localparam int TIMEOUT_CYC_DEF = 60;
  localparam int PULSE_W_DEF     = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_VEND     = 3'd1,
    ST_PULSE    = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_FAULT    = 3'd4
  } dispense_state_t;

endpackage

// File: rtl/vend_timeout_cnt.sv
// Clear/enable cycle counter with a terminal flag at TIMEOUT_CYC-1.
module vend_timeout_cnt #(
  parameter int TIMEOUT_CYC = 60
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic term
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  assign term = (count == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Turns each new sale/refund from the vending FSM into a motor run followed
// by one hopper pulse/ack round per yuan of change.
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int PULSE_W     = PULSE_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [GOODS_W-1:0]  sell,
  input  logic [CHANGE_W-1:0] change,
  input  logic                motor_done,
  input  logic                hopper_ack,
  input  logic                fault_clr,
  output logic                motor_en,
  output logic [GOODS_W-1:0]  motor_sel,
  output logic                coin_pulse,
  output logic                busy,
  output logic                fault,
  output logic                overrun
);

  localparam int PW = $clog2(PULSE_W + 1);

  dispense_state_t               state;
  logic [GOODS_W+CHANGE_W-1:0]   req;
  logic [GOODS_W+CHANGE_W-1:0]   prev_req;
  logic                          new_req;
  logic [CHANGE_W-1:0]           change_left;
  logic [CHANGE_W-1:0]           change_dec;
  logic [PW-1:0]                 pulse_cnt;
  logic                          tmo_en;
  logic                          tmo_clr;
  logic                          tmo_term;

  // A request is a change of the held {sell,change} pair to a non-zero value.
  assign req        = {sell, change};
  assign new_req    = (req != prev_req) && (req != '0);
  assign change_dec = (change_left != '0) ? change_left - CHANGE_W'(1) : change_left;

  assign tmo_en  = (state == ST_VEND) || (state == ST_WAIT_ACK);
  assign tmo_clr = !tmo_en
                 || ((state == ST_VEND) && motor_done)
                 || ((state == ST_WAIT_ACK) && hopper_ack);

  assign busy  = (state != ST_IDLE);
  assign fault = (state == ST_FAULT);

  vend_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_tmo (
    .clk (clk),
    .rst (rst),
    .clr (tmo_clr),
    .en  (tmo_en),
    .term(tmo_term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      prev_req    <= '0;
      change_left <= '0;
      pulse_cnt   <= '0;
      motor_en    <= 1'b0;
      motor_sel   <= '0;
      coin_pulse  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      prev_req <= req;
      if (new_req && (state != ST_IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (new_req) begin
            change_left <= change;
            if (sell != '0) begin
              motor_en  <= 1'b1;
              motor_sel <= sell;
              state     <= ST_VEND;
            end else begin
              coin_pulse <= 1'b1;
              pulse_cnt  <= '0;
              state      <= ST_PULSE;
            end
          end
        end
        ST_VEND: begin
          // Done is checked first so it beats a same-cycle timeout.
          if (motor_done) begin
            motor_en  <= 1'b0;
            motor_sel <= '0;
            if (change_left != '0) begin
              coin_pulse <= 1'b1;
              pulse_cnt  <= '0;
              state      <= ST_PULSE;
            end else begin
              state <= ST_IDLE;
            end
          end else if (tmo_term) begin
            motor_en  <= 1'b0;
            motor_sel <= '0;
            state     <= ST_FAULT;
          end
        end
        ST_PULSE: begin
          if (pulse_cnt == PW'(PULSE_W - 1)) begin
            coin_pulse <= 1'b0;
            state      <= ST_WAIT_ACK;
          end else begin
            pulse_cnt <= pulse_cnt + PW'(1);
          end
        end
        ST_WAIT_ACK: begin
          if (hopper_ack) begin
            change_left <= change_dec;
            if (change_dec != '0) begin
              coin_pulse <= 1'b1;
              pulse_cnt  <= '0;
              state      <= ST_PULSE;
            end else begin
              state <= ST_IDLE;
            end
          end else if (tmo_term) begin
            state <= ST_FAULT;
          end
        end
        ST_FAULT: begin
          if (fault_clr) begin
            change_left <= '0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Bench for vend_dispense_ctrl: a per-cycle vector table plus reactive
// motor/hopper sequences for the multi-cycle cases.
module tb_vend_dispense_ctrl;

  localparam int PULSE_W = 4;
  localparam int TMO     = 60;

  logic       clk;
  logic       rst;
  logic [2:0] sell;
  logic [2:0] change;
  logic       motor_done;
  logic       hopper_ack;
  logic       fault_clr;
  logic       motor_en;
  logic [2:0] motor_sel;
  logic       coin_pulse;
  logic       busy;
  logic       fault;
  logic       overrun;

  int total;
  int bad;

  // session results
  int r_me, r_pulses, r_wbad, r_selbad, r_wait, r_timeout;
  int r_end_busy, r_end_fault;

  vend_dispense_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .sell      (sell),
    .change    (change),
    .motor_done(motor_done),
    .hopper_ack(hopper_ack),
    .fault_clr (fault_clr),
    .motor_en  (motor_en),
    .motor_sel (motor_sel),
    .coin_pulse(coin_pulse),
    .busy      (busy),
    .fault     (fault),
    .overrun   (overrun)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] sell;
    logic [2:0] change;
    logic       done;
    logic       ack;
    logic [7:0] exp;  // {motor_en, motor_sel, coin_pulse, busy, fault, overrun}
  } vec_t;

  vec_t tbl[24];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {motor_en, motor_sel, coin_pulse, busy, fault, overrun};
  endfunction

  // Reactive motor/hopper model; stops when busy falls, on fault, or on budget.
  task automatic run_session(input int done_dly, input int ack_dly, input bit ack_in_pulse,
                             input logic [2:0] exp_sel, input int swap_at,
                             input logic [2:0] swap_sell, input logic [2:0] swap_change,
                             input int max_cyc);
    int me_run, cp_run, wait_run;
    bit pending, seen_busy, prev_cp, finished;
    me_run = 0; cp_run = 0; wait_run = 0;
    pending = 0; seen_busy = 0; prev_cp = 0; finished = 0;
    r_me = 0; r_pulses = 0; r_wbad = 0; r_selbad = 0; r_wait = 0; r_timeout = 0;
    for (int c = 0; c < max_cyc; c++) begin
      tick();
      motor_done = 1'b0;
      hopper_ack = 1'b0;
      if (motor_en) begin
        me_run++;
        r_me++;
        if (motor_sel != exp_sel) r_selbad++;
      end else begin
        me_run = 0;
        if (motor_sel != 3'd0) r_selbad++;
      end
      if (coin_pulse) begin
        if (!prev_cp) r_pulses++;
        cp_run++;
        pending = 0;
      end else if (prev_cp) begin
        if (cp_run != PULSE_W) r_wbad++;
        cp_run   = 0;
        pending  = 1;
        wait_run = 0;
      end
      prev_cp = coin_pulse;
      if (pending && !fault) begin
        wait_run++;
        r_wait = wait_run;
      end
      if (busy) seen_busy = 1;
      if (fault || (seen_busy && !busy)) begin
        finished = 1;
        break;
      end
      if (motor_en && me_run == swap_at) begin
        sell   = swap_sell;
        change = swap_change;
      end
      if (motor_en && me_run == done_dly) motor_done = 1'b1;
      if (ack_in_pulse && coin_pulse) hopper_ack = 1'b1;
      if (pending && ack_dly >= 0 && (wait_run - 1) == ack_dly) hopper_ack = 1'b1;
    end
    r_timeout   = finished ? 0 : 1;
    r_end_busy  = int'(busy);
    r_end_fault = int'(fault);
    motor_done  = 1'b0;
    hopper_ack  = 1'b0;
  endtask

  task automatic idle_activity(input int n, output int act);
    act = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (motor_en || coin_pulse || busy || fault) act++;
    end
  endtask

  initial begin
    int act;
    total = 0;
    bad   = 0;
    rst = 1'b1; sell = 3'd0; change = 3'd0;
    motor_done = 1'b0; hopper_ack = 1'b0; fault_clr = 1'b0;

    //         rst   sell  chg   done  ack   me   sel  cp   busy flt  ovr
    tbl[0]  = '{1'b1, 3'd0, 3'd0, 1'b0, 1'b0, {1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[1]  = '{1'b0, 3'd2, 3'd1, 1'b0, 1'b0, {1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0}};
    tbl[2]  = '{1'b0, 3'd2, 3'd1, 1'b0, 1'b0, {1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0}};
    tbl[3]  = '{1'b0, 3'd2, 3'd1, 1'b1, 1'b0, {1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[4]  = '{1'b0, 3'd2, 3'd1, 1'b0, 1'b0, {1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[5]  = '{1'b0, 3'd2, 3'd1, 1'b0, 1'b0, {1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[6]  = '{1'b0, 3'd2, 3'd1, 1'b0, 1'b0, {1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[7]  = '{1'b0, 3'd2, 3'd1, 1'b0, 1'b0, {1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0}};
    tbl[8]  = '{1'b0, 3'd2, 3'd1, 1'b0, 1'b1, {1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[9]  = '{1'b0, 3'd0, 3'd0, 1'b0, 1'b0, {1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[10] = '{1'b0, 3'd0, 3'd1, 1'b0, 1'b0, {1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[11] = '{1'b0, 3'd0, 3'd1, 1'b0, 1'b1, {1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[12] = '{1'b0, 3'd0, 3'd1, 1'b0, 1'b0, {1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[13] = '{1'b0, 3'd0, 3'd1, 1'b0, 1'b0, {1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[14] = '{1'b0, 3'd0, 3'd1, 1'b0, 1'b0, {1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0}};
    tbl[15] = '{1'b0, 3'd0, 3'd1, 1'b0, 1'b1, {1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[16] = '{1'b0, 3'd3, 3'd0, 1'b0, 1'b0, {1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0}};
    tbl[17] = '{1'b0, 3'd1, 3'd0, 1'b0, 1'b0, {1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1}};
    tbl[18] = '{1'b0, 3'd1, 3'd0, 1'b1, 1'b0, {1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1}};
    tbl[19] = '{1'b0, 3'd1, 3'd0, 1'b0, 1'b0, {1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1}};
    tbl[20] = '{1'b1, 3'd1, 3'd0, 1'b0, 1'b0, {1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[21] = '{1'b0, 3'd1, 3'd0, 1'b0, 1'b0, {1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0}};
    tbl[22] = '{1'b0, 3'd1, 3'd0, 1'b0, 1'b0, {1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0}};
    tbl[23] = '{1'b1, 3'd0, 3'd0, 1'b0, 1'b0, {1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0}};

    for (int i = 0; i < 24; i++) begin
      rst        = tbl[i].rst;
      sell       = tbl[i].sell;
      change     = tbl[i].change;
      motor_done = tbl[i].done;
      hopper_ack = tbl[i].ack;
      tick();
      check($sformatf("vec%0d_outs", i), int'(outs()), int'(tbl[i].exp));
    end
    rst = 1'b0; motor_done = 1'b0; hopper_ack = 1'b0;

    // sale with 3 yuan change
    sell = 3'd2; change = 3'd3;
    run_session(5, 2, 1'b0, 3'd2, -1, 3'd0, 3'd0, 300);
    check("s1_timeout",      r_timeout,   0);
    check("s1_motor_cycles", r_me,        5);
    check("s1_motor_sel",    r_selbad,    0);
    check("s1_pulses",       r_pulses,    3);
    check("s1_pulse_width",  r_wbad,      0);
    check("s1_busy_end",     r_end_busy,  0);
    check("s1_fault",        r_end_fault, 0);
    check("s1_overrun",      int'(overrun), 0);

    // refund of 5, immediate acks
    sell = 3'd0; change = 3'd5;
    run_session(-1, 0, 1'b0, 3'd0, -1, 3'd0, 3'd0, 300);
    check("s2_timeout",      r_timeout,   0);
    check("s2_motor_cycles", r_me,        0);
    check("s2_pulses",       r_pulses,    5);
    check("s2_pulse_width",  r_wbad,      0);
    check("s2_fault",        r_end_fault, 0);

    // motor never finishes
    sell = 3'd1; change = 3'd0;
    run_session(-1, -1, 1'b0, 3'd1, -1, 3'd0, 3'd0, 300);
    check("s3_timeout",      r_timeout,   0);
    check("s3_motor_cycles", r_me,        TMO);
    check("s3_fault",        r_end_fault, 1);
    check("s3_busy",         r_end_busy,  1);
    check("s3_pulses",       r_pulses,    0);
    check("s3_motor_off",    int'(motor_en), 0);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("s3_clr_fault", int'(fault), 0);
    check("s3_clr_busy",  int'(busy),  0);
    idle_activity(5, act);
    check("s3_quiet_after_clr", act, 0);

    // second request arrives mid-vend
    sell = 3'd3; change = 3'd2;
    run_session(5, 1, 1'b0, 3'd3, 2, 3'd1, 3'd4, 300);
    check("s4_timeout",      r_timeout, 0);
    check("s4_overrun",      int'(overrun), 1);
    check("s4_motor_cycles", r_me,      5);
    check("s4_motor_sel",    r_selbad,  0);
    check("s4_pulses",       r_pulses,  2);
    idle_activity(10, act);
    check("s4_not_served", act, 0);

    // ack only during PULSE, then silent hopper
    sell = 3'd0; change = 3'd2;
    run_session(-1, -1, 1'b1, 3'd0, -1, 3'd0, 3'd0, 300);
    check("s5_timeout",    r_timeout,   0);
    check("s5_pulses",     r_pulses,    1);
    check("s5_fault",      r_end_fault, 1);
    check("s5_wait_cycles", r_wait,     TMO);
    check("s5_cp_off",     int'(coin_pulse), 0);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("s5_clr_fault", int'(fault), 0);

    // reset in the middle of the second coin pulse
    sell = 3'd0; change = 3'd3;
    tick();
    check("s6_first_pulse", int'(coin_pulse), 1);
    tick(); tick(); tick();
    tick();
    check("s6_wait_ack", int'(coin_pulse), 0);
    hopper_ack = 1'b1;
    tick();
    hopper_ack = 1'b0;
    tick();
    check("s6_second_pulse", int'(coin_pulse), 1);
    rst = 1'b1; sell = 3'd0; change = 3'd0;
    tick();
    check("s6_reset_outputs", int'(outs()), 0);
    rst = 1'b0;
    idle_activity(10, act);
    check("s6_quiet", act, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
